// File: rtl/pong_game_sequencer_if.sv
// Player/control inputs and game-state outputs of the Pong sequencer.
// The slave side is the sequencer itself.
interface pong_game_sequencer_if;
    logic       iSW;
    logic       iUP1;
    logic       iDOWN1;
    logic       iUP2;
    logic       iDOWN2;
    logic [9:0] oP1Y;
    logic [9:0] oP2Y;
    logic [9:0] oBALL_X;
    logic [9:0] oBALL_Y;
    logic [3:0] oP1SCORE;
    logic [3:0] oP2SCORE;
    logic [2:0] oSTATE;
    logic [1:0] oWINNER;
    logic       oTICK;

    modport master (
        output iSW, iUP1, iDOWN1, iUP2, iDOWN2,
        input  oP1Y, oP2Y, oBALL_X, oBALL_Y,
        input  oP1SCORE, oP2SCORE, oSTATE, oWINNER, oTICK
    );

    modport slave (
        input  iSW, iUP1, iDOWN1, iUP2, iDOWN2,
        output oP1Y, oP2Y, oBALL_X, oBALL_Y,
        output oP1SCORE, oP2SCORE, oSTATE, oWINNER, oTICK
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong game-state controller: paddles, ball and scores advanced on a
// divided game tick through serve -> play -> point -> game-over.
module pong_game_sequencer #(
    parameter int TICK_DIV   = 1048576,
    parameter int FIELD_TOP  = 80,
    parameter int FIELD_BOT  = 450,
    parameter int FIELD_L    = 240,
    parameter int FIELD_R    = 400,
    parameter int P1_X       = 220,
    parameter int P2_X       = 400,
    parameter int PAD_W      = 20,
    parameter int PAD_H      = 80,
    parameter int BALL_R     = 7,
    parameter int WIN_SCORE  = 11,
    parameter int SERVE_WAIT = 64
) (
    input logic                  iVGA_CLK,
    input logic                  reset,
    pong_game_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;

    localparam logic [9:0] PAD_MIN = 10'(FIELD_TOP);
    localparam logic [9:0] PAD_MAX = 10'(FIELD_BOT - PAD_H);
    localparam logic [9:0] PAD0    = 10'((FIELD_TOP + FIELD_BOT - PAD_H) / 2);
    localparam logic [9:0] BX0     = 10'((FIELD_L + FIELD_R) / 2);
    localparam logic [9:0] BY0     = 10'((FIELD_TOP + FIELD_BOT) / 2);
    localparam logic [3:0] WIN     = 4'(WIN_SCORE);

    localparam logic signed [10:0] R   = 11'(BALL_R);
    localparam logic signed [10:0] TOP = 11'(FIELD_TOP);
    localparam logic signed [10:0] BOT = 11'(FIELD_BOT);
    localparam logic signed [10:0] GL  = 11'(FIELD_L);
    localparam logic signed [10:0] GR  = 11'(FIELD_R);
    localparam logic signed [10:0] P1F = 11'(P1_X + PAD_W);
    localparam logic signed [10:0] P2F = 11'(P2_X);
    localparam logic signed [10:0] PH  = 11'(PAD_H);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    up1_q, dn1_q, up2_q, dn2_q;

    state_t        state, state_n;
    logic [9:0]    p1y, p1y_n, p2y, p2y_n;
    logic [9:0]    bx, bx_n, by, by_n;
    logic          dxn, dxn_n, dyn, dyn_n;
    logic [3:0]    s1, s1_n, s2, s2_n;
    logic [1:0]    win, win_n;
    logic          p2pt, p2pt_n;
    logic [SW-1:0] scnt, scnt_n;

    logic wall_top, wall_bot, p1_hit, p2_hit, goal_l, goal_r;
    logic dx_play, dy_play;
    logic [3:0] s1_inc, s2_inc;

    // Signed 11-bit view so edge tests near zero cannot underflow
    function automatic logic signed [10:0] sx(input logic [9:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [9:0] pad(
        input logic [9:0] y,
        input logic       up,
        input logic       dn
    );
        unique case (1'b1)
            (!up && dn && (y > PAD_MIN)): pad = y - 10'd1;
            (up && !dn && (y < PAD_MAX)): pad = y + 10'd1;
            default:                      pad = y;
        endcase
    endfunction

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            tick  <= 1'b0;
            up1_q <= 2'b11;
            dn1_q <= 2'b11;
            up2_q <= 2'b11;
            dn2_q <= 2'b11;
        end else begin
            tick  <= (cnt == CW'(TICK_DIV - 1));
            cnt   <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
            up1_q <= {up1_q[0], bus.iUP1};
            dn1_q <= {dn1_q[0], bus.iDOWN1};
            up2_q <= {up2_q[0], bus.iUP2};
            dn2_q <= {dn2_q[0], bus.iDOWN2};
        end
    end

    assign wall_top = dyn && (sx(by) - R <= TOP);
    assign wall_bot = !dyn && (sx(by) + R >= BOT);
    assign p1_hit   = dxn && (sx(bx) - R <= P1F)
                   && (sx(by) >= sx(p1y)) && (sx(by) <= sx(p1y) + PH);
    assign p2_hit   = !dxn && (sx(bx) + R >= P2F)
                   && (sx(by) >= sx(p2y)) && (sx(by) <= sx(p2y) + PH);
    assign goal_l   = (sx(bx) - R <= GL);
    assign goal_r   = (sx(bx) + R >= GR);
    assign dy_play  = wall_top ? 1'b0 : (wall_bot ? 1'b1 : dyn);
    assign dx_play  = p1_hit ? 1'b0 : (p2_hit ? 1'b1 : dxn);
    assign s1_inc   = (s1 >= WIN) ? s1 : s1 + 4'd1;
    assign s2_inc   = (s2 >= WIN) ? s2 : s2 + 4'd1;

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            p1y   <= PAD0;
            p2y   <= PAD0;
            bx    <= BX0;
            by    <= BY0;
            dxn   <= 1'b1;
            dyn   <= 1'b0;
            s1    <= '0;
            s2    <= '0;
            win   <= '0;
            p2pt  <= 1'b0;
            scnt  <= '0;
        end else begin
            state <= state_n;
            p1y   <= p1y_n;
            p2y   <= p2y_n;
            bx    <= bx_n;
            by    <= by_n;
            dxn   <= dxn_n;
            dyn   <= dyn_n;
            s1    <= s1_n;
            s2    <= s2_n;
            win   <= win_n;
            p2pt  <= p2pt_n;
            scnt  <= scnt_n;
        end
    end

    always_comb begin
        state_n = state;
        p1y_n   = p1y;
        p2y_n   = p2y;
        bx_n    = bx;
        by_n    = by;
        dxn_n   = dxn;
        dyn_n   = dyn;
        s1_n    = s1;
        s2_n    = s2;
        win_n   = win;
        p2pt_n  = p2pt;
        scnt_n  = scnt;
        if (bus.iSW) begin
            state_n = S_IDLE;
            p1y_n   = PAD0;
            p2y_n   = PAD0;
            bx_n    = BX0;
            by_n    = BY0;
            dxn_n   = 1'b1;
            dyn_n   = 1'b0;
            s1_n    = '0;
            s2_n    = '0;
            win_n   = '0;
            p2pt_n  = 1'b0;
            scnt_n  = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_SERVE;
                    scnt_n  = '0;
                end
                S_SERVE: if (tick) begin
                    p1y_n = pad(p1y, up1_q[1], dn1_q[1]);
                    p2y_n = pad(p2y, up2_q[1], dn2_q[1]);
                    if (scnt == SW'(SERVE_WAIT - 1)) begin
                        state_n = S_PLAY;
                        scnt_n  = '0;
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
                S_PLAY: if (tick) begin
                    p1y_n = pad(p1y, up1_q[1], dn1_q[1]);
                    p2y_n = pad(p2y, up2_q[1], dn2_q[1]);
                    dyn_n = dy_play;
                    dxn_n = dx_play;
                    // A paddle hit takes priority over the goal line behind it
                    if (!p1_hit && !p2_hit && (goal_l || goal_r)) begin
                        state_n = S_POINT;
                        p2pt_n  = goal_l;
                    end else begin
                        bx_n = dx_play ? bx - 10'd1 : bx + 10'd1;
                        by_n = dy_play ? by - 10'd1 : by + 10'd1;
                    end
                end
                S_POINT: if (tick) begin
                    p1y_n = pad(p1y, up1_q[1], dn1_q[1]);
                    p2y_n = pad(p2y, up2_q[1], dn2_q[1]);
                    s1_n  = p2pt ? s1 : s1_inc;
                    s2_n  = p2pt ? s2_inc : s2;
                    if ((p2pt ? s2_inc : s1_inc) == WIN) begin
                        state_n = S_OVER;
                        win_n   = p2pt ? 2'd2 : 2'd1;
                    end else begin
                        state_n = S_SERVE;
                        scnt_n  = '0;
                        bx_n    = BX0;
                        by_n    = BY0;
                        dxn_n   = p2pt;
                    end
                end
                S_OVER: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.oP1Y     = p1y;
        bus.oP2Y     = p2y;
        bus.oBALL_X  = bx;
        bus.oBALL_Y  = by;
        bus.oP1SCORE = s1;
        bus.oP2SCORE = s2;
        bus.oSTATE   = state;
        bus.oWINNER  = win;
        bus.oTICK    = tick;
    end
endmodule
